// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder: field-level request in, encoded word out.
interface inst_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_fun3;
   logic [6:0]  in_fun7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic [2:0]  fifo_count;

   modport master (
      output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_fun3, in_fun7, in_imm,
      output out_ready,
      input  in_ready, out_valid, out_inst, out_err, fifo_count
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_fun3, in_fun7, in_imm,
      input  out_ready,
      output in_ready, out_valid, out_inst, out_err, fifo_count
   );
endinterface

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs fields into a 32-bit word and queues it in a 4-entry FIFO.
// Define INST_ENC_RANGE_CHK_EN to add a per-entry immediate range/format error flag.
module inst_encoder (
   input  logic          clk,
   input  logic          rst_n,
   inst_encoder_if.slave bus
);
   logic [31:0] enc_word;
   logic [31:0] mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic        push;
   logic        pop;
   logic        shift_imm;

   assign bus.in_ready   = (count < 3'd4);
   assign bus.out_valid  = (count != 3'd0);
   assign bus.fifo_count = count;
   assign push           = bus.in_valid & bus.in_ready;
   assign pop            = bus.out_valid & bus.out_ready;
   // Empty FIFO drives zero so reset shows a clean word without clearing the array.
   assign bus.out_inst   = bus.out_valid ? mem[rd_ptr] : 32'h0;

   // Shift-immediate ops carry fun7 in the upper immediate slot.
   assign shift_imm = (bus.in_opcode == 7'b0010011) && (bus.in_fun3[1:0] == 2'b01);

   always_comb begin
      enc_word = 32'h0000_0013;
      case (bus.in_fmt)
         3'd0: enc_word = {bus.in_fun7, bus.in_rs2, bus.in_rs1, bus.in_fun3, bus.in_rd, bus.in_opcode};
         3'd1: begin
            if (shift_imm)
               enc_word = {bus.in_fun7, bus.in_imm[4:0], bus.in_rs1, bus.in_fun3, bus.in_rd, bus.in_opcode};
            else
               enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_fun3, bus.in_rd, bus.in_opcode};
         end
         3'd2: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_fun3,
                           bus.in_imm[4:0], bus.in_opcode};
         3'd3: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_fun3,
                           bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
         3'd4: enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
         3'd5: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                           bus.in_rd, bus.in_opcode};
         default: enc_word = 32'h0000_0013;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= enc_word;
   end

`ifdef INST_ENC_RANGE_CHK_EN
   logic err_now;
   logic err_mem [4];

   // An immediate is a valid N-bit sign extension when imm[31:N-1] are all equal.
   always_comb begin
      err_now = 1'b0;
      case (bus.in_fmt)
         3'd0:       err_now = 1'b0;
         3'd1, 3'd2: err_now = ~((&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]));
         3'd3:       err_now = bus.in_imm[0] | ~((&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]));
         3'd4:       err_now = |bus.in_imm[11:0];
         3'd5:       err_now = bus.in_imm[0] | ~((&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20]));
         default:    err_now = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) err_mem[wr_ptr] <= err_now;
   end

   assign bus.out_err = bus.out_valid & err_mem[rd_ptr];
`else
   assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed encodings, full/drain, async reset, random traffic.
module tb_inst_encoder;
   logic clk;
   logic rst_n;

   inst_encoder_if bus ();

   inst_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] inst;
      logic        err;
   } sb_item_t;

   sb_item_t sb[$];
   int checks = 0;
   int errors = 0;

   logic [2:0]  r_fmt;
   logic [6:0]  r_op;
   logic [4:0]  r_rd;
   logic [4:0]  r_rs1;
   logic [4:0]  r_rs2;
   logic [2:0]  r_f3;
   logic [6:0]  r_f7;
   logic [31:0] r_imm;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_enc();
      logic [31:0] w;
      logic [31:0] regs;
      regs = (32'(r_rs1) << 15) | (32'(r_f3) << 12);
      case (r_fmt)
         3'd0: w = (32'(r_f7) << 25) | (32'(r_rs2) << 20) | regs | (32'(r_rd) << 7) | 32'(r_op);
         3'd1: begin
            if (r_op == 7'h13 && (r_f3 == 3'd1 || r_f3 == 3'd5))
               w = (32'(r_f7) << 25) | ((r_imm & 32'h1F) << 20) | regs | (32'(r_rd) << 7) | 32'(r_op);
            else
               w = ((r_imm & 32'hFFF) << 20) | regs | (32'(r_rd) << 7) | 32'(r_op);
         end
         3'd2: w = (((r_imm >> 5) & 32'h7F) << 25) | (32'(r_rs2) << 20) | regs
                   | ((r_imm & 32'h1F) << 7) | 32'(r_op);
         3'd3: w = (((r_imm >> 12) & 32'h1) << 31) | (((r_imm >> 5) & 32'h3F) << 25)
                   | (32'(r_rs2) << 20) | regs | (((r_imm >> 1) & 32'hF) << 8)
                   | (((r_imm >> 11) & 32'h1) << 7) | 32'(r_op);
         3'd4: w = (r_imm & 32'hFFFF_F000) | (32'(r_rd) << 7) | 32'(r_op);
         3'd5: w = (((r_imm >> 20) & 32'h1) << 31) | (((r_imm >> 1) & 32'h3FF) << 21)
                   | (((r_imm >> 11) & 32'h1) << 20) | (((r_imm >> 12) & 32'hFF) << 12)
                   | (32'(r_rd) << 7) | 32'(r_op);
         default: w = 32'h0000_0013;
      endcase
      return w;
   endfunction

   function automatic logic ref_err();
`ifdef INST_ENC_RANGE_CHK_EN
      int s;
      s = int'(r_imm);
      case (r_fmt)
         3'd1, 3'd2: return (s < -2048) || (s > 2047);
         3'd3:       return ((r_imm % 2) != 0) || (s < -4096) || (s > 4095);
         3'd4:       return (r_imm % 4096) != 0;
         3'd5:       return ((r_imm % 2) != 0) || (s < -1048576) || (s > 1048575);
         3'd6, 3'd7: return 1'b1;
         default:    return 1'b0;
      endcase
`else
      return 1'b0;
`endif
   endfunction

   task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
      r_fmt = fmt; r_op = op; r_rd = rd; r_rs1 = rs1; r_rs2 = rs2; r_f3 = f3; r_f7 = f7; r_imm = imm;
   endtask

   // Drives one cycle of stimulus; acceptance is judged just before the capturing edge.
   task automatic step(input logic v, input logic ovr, input logic fixed_en,
                       input logic [31:0] fixed_inst, output logic acc);
      sb_item_t it;
      @(posedge clk); #1;
      bus.in_valid  = v;
      bus.in_fmt    = r_fmt;
      bus.in_opcode = r_op;
      bus.in_rd     = r_rd;
      bus.in_rs1    = r_rs1;
      bus.in_rs2    = r_rs2;
      bus.in_fun3   = r_f3;
      bus.in_fun7   = r_f7;
      bus.in_imm    = r_imm;
      bus.out_ready = ovr;
      @(negedge clk);
      acc = v && bus.in_ready;
      if (acc) begin
         it.inst = fixed_en ? fixed_inst : ref_enc();
         it.err  = ref_err();
         sb.push_back(it);
      end
   endtask

   task automatic drain(input int max_cycles);
      logic acc;
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         step(1'b0, 1'b1, 1'b0, 32'h0, acc);
         n++;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, acc);
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: head must match scoreboard whenever presented; pop on handshake.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%08h expected no entry", bus.out_inst);
         end else begin
            chk("head_inst", bus.out_inst, sb[0].inst);
            chk("head_err", 32'(bus.out_err), 32'(sb[0].err));
            if (bus.out_ready) void'(sb.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("fifo_count", 32'(bus.fifo_count), 32'(sb.size()));
         chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < 4));
         chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      end
   end

   initial begin
      logic acc;
      int   nacc;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      bus.in_fmt = 3'd0; bus.in_opcode = 7'd0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0;
      bus.in_rs2 = 5'd0; bus.in_fun3 = 3'd0; bus.in_fun7 = 7'd0; bus.in_imm = 32'd0;
      rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_inst", bus.out_inst, 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with known encodings
      set_fields(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      step(1'b1, 1'b0, 1'b1, 32'h002081B3, acc);
      step(1'b0, 1'b0, 1'b0, 32'h0, acc);
      chk("add_latency_valid", 32'(bus.out_valid), 32'd1);
      drain(10);
      set_fields(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b1, 32'hFE208EE3, acc);
      set_fields(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
      step(1'b1, 1'b0, 1'b1, 32'h008000EF, acc);
      set_fields(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
      step(1'b1, 1'b0, 1'b1, 32'h80000093, acc);
      set_fields(3'd6, 7'h7F, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 1'b1, 32'h00000013, acc);
      drain(10);

      // Fill: five back-to-back requests with consumer stalled
      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         set_fields(3'd0, 7'b0110011, 5'(i + 1), 5'(i), 5'(i + 2), 3'd0, 7'd0, 32'd0);
         step(1'b1, 1'b0, 1'b0, 32'h0, acc);
         if (acc) nacc++;
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, acc);
      chk("full_accepted", 32'(nacc), 32'd4);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_count", 32'(bus.fifo_count), 32'd4);
      drain(10);

      // Async reset with three entries held
      for (int i = 0; i < 3; i++) begin
         set_fields(3'd4, 7'b0110111, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1) << 12);
         step(1'b1, 1'b0, 1'b0, 32'h0, acc);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      #2;
      chk("pre_rst_count", 32'(bus.fifo_count), 32'd3);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_out_inst", bus.out_inst, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         logic [31:0] imm;
         logic [6:0]  op;
         int          sv;
         sv  = int'($urandom_range(0, 8191)) - 4096;
         imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'(sv);
         if ($urandom_range(0, 3) == 0) imm = imm & 32'hFFFF_F000;
         op  = ($urandom_range(0, 3) == 0) ? 7'h13 : 7'($urandom);
         set_fields(3'($urandom_range(0, 7)), op, 5'($urandom), 5'($urandom), 5'($urandom),
                    3'($urandom), 7'($urandom), imm);
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), 1'b0, 32'h0, acc);
      end
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish by 200000");
      $fatal(1);
   end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL provide port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL provide port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL provide port in_valid, input, 1, request carries fields to encode.
REQ-004 SHALL provide port in_ready, output, 1, encoder can accept a request this cycle.
REQ-005 SHALL provide port in_fmt, input, 3; 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7=illegal.
REQ-006 SHALL provide port in_opcode, input, 7, placed verbatim at inst[6:0].
REQ-007 SHALL provide ports in_rd, in_rs1, in_rs2, input, 5 each, register indices.
REQ-008 SHALL provide ports in_fun3 (input, 3) and in_fun7 (input, 7).
REQ-009 SHALL provide port in_imm, input, 32, unscrambled sign-extended immediate.
REQ-010 SHALL provide port out_valid, output, 1, head entry valid.
REQ-011 SHALL provide port out_ready, input, 1, consumer takes head.
REQ-012 SHALL provide port out_inst, output, 32, encoded instruction at FIFO head.
REQ-013 SHALL provide port out_err, output, 1, error flag of head entry.
REQ-014 SHALL provide port fifo_count, output, 3, entries held, 0..4.

Function
REQ-015 SHALL accept a request on a cycle with in_valid & in_ready and push encoded word into a 4-entry FIFO.
REQ-016 SHALL assert in_ready iff fifo_count < 4; no push when full, even with a same-cycle pop.
REQ-017 SHALL pop head on out_valid & out_ready; out_valid = (fifo_count != 0).
REQ-018 SHALL present an accepted word on out_inst no earlier than the cycle after acceptance (latency 1 into empty FIFO).
REQ-019 SHALL keep fifo_count unchanged on simultaneous push and pop; order strictly FIFO; pointers wrap modulo 4.
REQ-020 SHALL hold out_inst/out_err stable while out_valid & ~out_ready.
REQ-021 R: {fun7, rs2, rs1, fun3, rd, opcode}.
REQ-022 I: {imm[11:0], rs1, fun3, rd, opcode}; when opcode=0010011 and fun3 in {001,101}, inst[31:25]=fun7 and inst[24:20]=imm[4:0].
REQ-023 S: {imm[11:5], rs2, rs1, fun3, imm[4:0], opcode}.
REQ-024 B: {imm[12], imm[10:5], rs2, rs1, fun3, imm[4:1], imm[11], opcode}.
REQ-025 U: {imm[31:12], rd, opcode}.
REQ-026 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-027 in_fmt 6/7 SHALL encode as 0x00000013 (NOP).
REQ-028 Unused fields for a format SHALL be ignored; imm bits outside the format are silently dropped.

Reset
REQ-029 rst_n low SHALL immediately clear pointers and count: out_valid=0, fifo_count=0, in_ready=1, out_inst=0, out_err=0.
REQ-030 Reset mid-operation SHALL discard all stored entries; no partial push survives.

Configuration
REQ-031 Macro INST_ENC_RANGE_CHK_EN defined: out_err per entry = 1 when fmt 6/7; I/S imm not a 12-bit sign extension; B imm[0]=1 or not a 13-bit sign extension; J imm[0]=1 or not a 21-bit sign extension; U imm[11:0]!=0; flagged entries are still pushed with the REQ-021..027 encoding.
REQ-032 Macro not defined: no range logic, out_err tied 0, error storage removed.

Verification
REQ-033 R add x3,x1,x2 (fmt0, op 0110011, rd3, rs1 1, rs2 2, fun3 0, fun7 0) into empty FIFO -> out_inst=0x002081B3, out_valid next cycle.
REQ-034 B beq x1,x2 imm=0xFFFFFFFC (op 1100011) -> out_inst=0xFE208EE3, out_err=0.
REQ-035 J jal x1 imm=8 (op 1101111) -> out_inst=0x008000EF.
REQ-036 out_ready=0, 5 back-to-back requests -> 4 accepted, in_ready=0, fifo_count=4; then out_ready=1 -> drained in order, one per cycle, in_ready=1 next cycle after first pop.
REQ-037 3 entries held, rst_n pulsed low mid-cycle -> out_valid=0, fifo_count=0 without waiting for clk.
REQ-038 I addi x1,x0 imm=0x800 (op 0010011) -> out_inst=0x80000093; out_err=1 with INST_ENC_RANGE_CHK_EN, 0 without.
